// File: rtl/data_structs_pkg.sv
// Shared fixed-point geometry types for the ray traversal datapath.
package data_structs;

    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_FRAC_W = 12;

    typedef logic signed [DEF_DATA_W-1:0] fix_t;

    typedef struct packed {
        fix_t z;
        fix_t y;
        fix_t x;
    } vec3_t;

    typedef struct packed {
        fix_t tfar;
        fix_t tnear;
    } vec2_t;

    typedef struct packed {
        vec3_t bmax;
        vec3_t bmin;
    } bbox_t;

endpackage

// File: rtl/ray_bbox_intersect_pipe_slab_child.sv
// Four-stage slab test of one ray against one axis-aligned box.
module ray_bbox_slab_child
    import data_structs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [3*DATA_W-1:0] ray_orig,
    input  logic [3*DATA_W-1:0] inv_dir,
    input  logic [6*DATA_W-1:0] box,
    input  logic [2*DATA_W-1:0] t_range,
    output logic [DATA_W-1:0]   tnear,
    output logic [DATA_W-1:0]   tfar,
    output logic                hit,
    output logic [DATA_W-1:0]   tnear_c,
    output logic                hit_c
);

    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam logic signed [PROD_W-1:0] T_MAX = {{(DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] T_MIN = {{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [DATA_W:0]   d_c [6];
    logic signed [DATA_W:0]   s1_d [6];
    logic [3*DATA_W-1:0]      s1_inv;
    logic [2*DATA_W-1:0]      s1_rng;
    logic signed [PROD_W-1:0] prod_c [6];
    logic signed [PROD_W-1:0] shr_c [6];
    logic signed [DATA_W-1:0] t_c [6];
    logic signed [DATA_W-1:0] s2_t [6];
    logic [2:0]               s2_neg;
    logic [2*DATA_W-1:0]      s2_rng;
    logic signed [DATA_W-1:0] rng_near;
    logic signed [DATA_W-1:0] rng_far;
    logic signed [DATA_W-1:0] lo_c [3];
    logic signed [DATA_W-1:0] hi_c [3];
    logic signed [DATA_W-1:0] tmin_c [3];
    logic signed [DATA_W-1:0] tmax_c [3];
    logic signed [DATA_W-1:0] s3_tmin [3];
    logic signed [DATA_W-1:0] s3_tmax [3];
    logic signed [DATA_W-1:0] tn_s;
    logic signed [DATA_W-1:0] tf_s;

    // Slab offsets, one extra bit so extreme bound/origin pairs cannot wrap
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            d_c[i] = {box[i*DATA_W + DATA_W - 1], box[i*DATA_W +: DATA_W]}
                   - {ray_orig[(i%3)*DATA_W + DATA_W - 1], ray_orig[(i%3)*DATA_W +: DATA_W]};
        end
    end

    // Scale by inverse direction and saturate back into the t word
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            prod_c[i] = $signed({{DATA_W{s1_d[i][DATA_W]}}, s1_d[i]})
                      * $signed({{(DATA_W + 1){s1_inv[(i%3)*DATA_W + DATA_W - 1]}},
                                 s1_inv[(i%3)*DATA_W +: DATA_W]});
            shr_c[i] = prod_c[i] >>> FRAC_W;
            if (shr_c[i] > T_MAX) begin
                t_c[i] = T_MAX[DATA_W-1:0];
            end else if (shr_c[i] < T_MIN) begin
                t_c[i] = T_MIN[DATA_W-1:0];
            end else begin
                t_c[i] = shr_c[i][DATA_W-1:0];
            end
        end
    end

    assign rng_near = s2_rng[DATA_W-1:0];
    assign rng_far  = s2_rng[2*DATA_W-1:DATA_W];

    // Order entry/exit per axis, then clip to the incoming interval
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            lo_c[a]   = s2_neg[a] ? s2_t[a+3] : s2_t[a];
            hi_c[a]   = s2_neg[a] ? s2_t[a] : s2_t[a+3];
            tmin_c[a] = (lo_c[a] > rng_near) ? lo_c[a] : rng_near;
            tmax_c[a] = (hi_c[a] < rng_far) ? hi_c[a] : rng_far;
        end
    end

    always_comb begin
        tn_s = s3_tmin[0];
        tf_s = s3_tmax[0];
        for (int a = 1; a < 3; a++) begin
            if (s3_tmin[a] > tn_s) tn_s = s3_tmin[a];
            if (s3_tmax[a] < tf_s) tf_s = s3_tmax[a];
        end
        tnear_c = tn_s;
        hit_c   = (tf_s > tn_s);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_d    <= d_c;
            s1_inv  <= inv_dir;
            s1_rng  <= t_range;
            s2_t    <= t_c;
            s2_neg  <= {s1_inv[3*DATA_W-1], s1_inv[2*DATA_W-1], s1_inv[DATA_W-1]};
            s2_rng  <= s1_rng;
            s3_tmin <= tmin_c;
            s3_tmax <= tmax_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tnear <= '0;
            tfar  <= '0;
            hit   <= 1'b0;
        end else if (en) begin
            tnear <= tn_s;
            tfar  <= tf_s;
            hit   <= hit_c;
        end
    end

endmodule

// File: rtl/ray_bbox_intersect_pipe.sv
// Ray vs NUM_CHILD boxes, 4-stage pipeline with nearest-hit select.
// Optional sideband tag enabled by defining RAY_BBOX_TAG_EN.
module ray_bbox_intersect_pipe
    import data_structs::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_W    = DEF_FRAC_W,
    parameter int unsigned NUM_CHILD = 2,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3*DATA_W-1:0]           in_ray_orig,
    input  logic [3*DATA_W-1:0]           in_inv_dir,
    input  logic [NUM_CHILD*6*DATA_W-1:0] in_boxes,
    input  logic [2*DATA_W-1:0]           in_range,
`ifdef RAY_BBOX_TAG_EN
    input  logic [TAG_W-1:0]              in_tag,
    output logic [TAG_W-1:0]              out_tag,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CHILD-1:0]          out_hit_mask,
    output logic [NUM_CHILD*DATA_W-1:0]   out_tnear,
    output logic [NUM_CHILD*DATA_W-1:0]   out_tfar,
    output logic                          out_any_hit,
    output logic [((NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1)-1:0] out_nearest_idx
);

    localparam int unsigned IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

    logic                     en;
    logic                     v1;
    logic                     v2;
    logic                     v3;
    logic [NUM_CHILD-1:0]     hit_c;
    logic [DATA_W-1:0]        tnear_c [NUM_CHILD];
    logic                     found;
    logic signed [DATA_W-1:0] best_t;
    logic [IDX_W-1:0]         best_idx;

    // Whole pipeline moves as one; a stalled output freezes every stage
    assign en       = !out_valid || out_ready;
    assign in_ready = en || rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
        end
    end

    for (genvar c = 0; c < NUM_CHILD; c++) begin : g_child
        ray_bbox_slab_child #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_slab (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .ray_orig (in_ray_orig),
            .inv_dir  (in_inv_dir),
            .box      (in_boxes[c*6*DATA_W +: 6*DATA_W]),
            .t_range  (in_range),
            .tnear    (out_tnear[c*DATA_W +: DATA_W]),
            .tfar     (out_tfar[c*DATA_W +: DATA_W]),
            .hit      (out_hit_mask[c]),
            .tnear_c  (tnear_c[c]),
            .hit_c    (hit_c[c])
        );
    end

    // Strict less-than keeps the lowest index on equal tnear
    always_comb begin
        found    = 1'b0;
        best_t   = '0;
        best_idx = '0;
        for (int c = 0; c < NUM_CHILD; c++) begin
            if (hit_c[c] && (!found || ($signed(tnear_c[c]) < best_t))) begin
                found    = 1'b1;
                best_t   = tnear_c[c];
                best_idx = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_any_hit     <= 1'b0;
            out_nearest_idx <= '0;
        end else if (en) begin
            out_any_hit     <= |hit_c;
            out_nearest_idx <= best_idx;
        end
    end

`ifdef RAY_BBOX_TAG_EN
    logic [TAG_W-1:0] tag_s1;
    logic [TAG_W-1:0] tag_s2;
    logic [TAG_W-1:0] tag_s3;

    always_ff @(posedge clk) begin
        if (en) begin
            tag_s1 <= in_tag;
            tag_s2 <= tag_s1;
            tag_s3 <= tag_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_tag <= '0;
        end else if (en) begin
            out_tag <= tag_s3;
        end
    end
`endif

endmodule
